// File: rtl/iter_alu_pkg.sv
// Shared opcode and state definitions for the iterative ALU and its multiply/divide unit.
package iter_alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_SLL   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_SLT   = 5'd8,
        OP_SLTU  = 5'd9,
        OP_BEQ   = 5'd10,
        OP_BNE   = 5'd11,
        OP_BLT   = 5'd12,
        OP_BGE   = 5'd13,
        OP_BLTU  = 5'd14,
        OP_BGEU  = 5'd15,
        OP_MUL   = 5'd16,
        OP_MULH  = 5'd17,
        OP_MULHU = 5'd18,
        OP_DIV   = 5'd19,
        OP_DIVU  = 5'd20,
        OP_REM   = 5'd21,
        OP_REMU  = 5'd22
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    // Multiply and divide codes go through the multi-cycle unit; everything else is single-cycle.
    function automatic logic is_iterative(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Shift-add multiplier and restoring divider sharing one hi/lo register pair.
// Works on operand magnitudes; the caller applies sign correction afterwards.
module iter_muldiv
    import iter_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  start,
    input  logic                  is_div,
    input  logic                  a_signed,
    input  logic                  b_signed,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [CW-1:0]         cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  div_q;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] a_mag, b_mag;
    logic [DATA_WIDTH:0]   add_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH:0]   div_diff;

    // One iteration: conditional add-and-shift for multiply, trial subtract for divide.
    always_comb begin
        a_mag     = (a_signed && op_a[DATA_WIDTH-1]) ? -op_a : op_a;
        b_mag     = (b_signed && op_b[DATA_WIDTH-1]) ? -op_b : op_b;
        add_sum   = {1'b0, hi_q} + {1'b0, b_q};
        div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (div_q) begin
            if (!div_diff[DATA_WIDTH]) begin
                hi_d = div_diff[DATA_WIDTH-1:0];
                lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_shift[DATA_WIDTH-1:0];
                lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            hi_d = add_sum[DATA_WIDTH:1];
            lo_d = {add_sum[0], lo_q[DATA_WIDTH-1:1]};
        end else begin
            hi_d = {1'b0, hi_q[DATA_WIDTH-1:1]};
            lo_d = {hi_q[0], lo_q[DATA_WIDTH-1:1]};
        end
    end

    // Load magnitudes on start, then run exactly DATA_WIDTH iterations before flagging done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            div_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else if (flush) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            div_q  <= is_div;
            hi_q   <= '0;
            lo_q   <= a_mag;
            b_q    <= b_mag;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                cnt_q  <= '0;
            end
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/iter_alu.sv
// Handshaked ALU: single-cycle integer/branch ops plus iterative RISC-V M-extension ops.
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_in_1,
    input  logic [DATA_WIDTH-1:0] alu_in_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  alu_bcond
);

    localparam int SW = $clog2(DATA_WIDTH);

    alu_state_e            state_q, state_d;
    logic [4:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  bcond_q, bcond_d;

    logic                  accept;
    logic                  start_iter;
    logic                  op_signed;
    logic                  op_is_div;
    logic                  md_done;
    logic [DATA_WIDTH-1:0] md_hi, md_lo;
    logic [SW-1:0]         shamt;
    logic [DATA_WIDTH-1:0] single_res;
    logic                  single_bc;
    logic [DATA_WIDTH-1:0] fix_res;
    logic [DATA_WIDTH-1:0] mulh_neg_hi;
    logic                  neg_a, neg_b;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_valid_q && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign op_signed = (alu_op == OP_MULH) || (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign op_is_div = (alu_op >= OP_DIV) && (alu_op <= OP_REMU);

    iter_muldiv #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .start    (start_iter),
        .is_div   (op_is_div),
        .a_signed (op_signed),
        .b_signed (op_signed),
        .op_a     (alu_in_1),
        .op_b     (alu_in_2),
        .done     (md_done),
        .hi       (md_hi),
        .lo       (md_lo)
    );

    // Single-cycle datapath evaluated from the captured operands.
    always_comb begin
        shamt      = b_q[SW-1:0];
        single_res = '0;
        single_bc  = 1'b0;
        case (op_q)
            OP_ADD:  single_res = a_q + b_q;
            OP_SUB:  single_res = a_q - b_q;
            OP_AND:  single_res = a_q & b_q;
            OP_OR:   single_res = a_q | b_q;
            OP_XOR:  single_res = a_q ^ b_q;
            OP_SLL:  single_res = a_q << shamt;
            OP_SRL:  single_res = a_q >> shamt;
            OP_SRA:  single_res = $signed(a_q) >>> shamt;
            OP_SLT:  single_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLTU: single_res = {{(DATA_WIDTH-1){1'b0}}, (a_q < b_q)};
            OP_BEQ:  single_bc  = (a_q == b_q);
            OP_BNE:  single_bc  = (a_q != b_q);
            OP_BLT:  single_bc  = ($signed(a_q) < $signed(b_q));
            OP_BGE:  single_bc  = ($signed(a_q) >= $signed(b_q));
            OP_BLTU: single_bc  = (a_q < b_q);
            OP_BGEU: single_bc  = (a_q >= b_q);
            default: ;
        endcase
    end

    // Sign correction of the magnitude result, plus divide-by-zero handling.
    always_comb begin
        neg_a       = a_q[DATA_WIDTH-1];
        neg_b       = b_q[DATA_WIDTH-1];
        mulh_neg_hi = ~md_hi + {{(DATA_WIDTH-1){1'b0}}, (md_lo == '0)};
        fix_res     = '0;
        case (op_q)
            OP_MUL:   fix_res = md_lo;
            OP_MULH:  fix_res = (neg_a ^ neg_b) ? mulh_neg_hi : md_hi;
            OP_MULHU: fix_res = md_hi;
            OP_DIV:   fix_res = (b_q == '0) ? '1 : ((neg_a ^ neg_b) ? -md_lo : md_lo);
            OP_DIVU:  fix_res = md_lo;
            OP_REM:   fix_res = (b_q == '0) ? a_q : (neg_a ? -md_hi : md_hi);
            OP_REMU:  fix_res = md_hi;
            default:  ;
        endcase
    end

    // Control FSM: flush wins, then result presentation, then accepting a new request.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        bcond_d     = bcond_q;
        start_iter  = 1'b0;
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_BUSY: begin
                    if (md_done) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_d     = ST_DONE;
                    result_d    = fix_res;
                    bcond_d     = 1'b0;
                    out_valid_d = 1'b1;
                end
                ST_DONE: begin
                    if (!out_valid_q) begin
                        result_d    = single_res;
                        bcond_d     = single_bc;
                        out_valid_d = 1'b1;
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: ;
            endcase
            if (accept) begin
                op_d        = alu_op;
                a_d         = alu_in_1;
                b_d         = alu_in_2;
                out_valid_d = 1'b0;
                if (is_iterative(alu_op)) begin
                    state_d    = ST_BUSY;
                    start_iter = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            bcond_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            bcond_q     <= bcond_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_result = result_q;
    assign alu_bcond  = bcond_q;

endmodule
